// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, IF_WAIT, LS_WAIT} arb_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int BE_W = 4;

    // The low two funct3 bits give the width; the unused codes 3, 6 and 7 fall into word.
    function automatic acc_size_t access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (access_size(funct3))
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte/halfword lane select with sign or zero extension (funct3[2] selects zero extension).
module load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [15:0] lane;

    always_comb begin
        lane = 16'(data >> {offset, 3'b000});
        case (access_size(funct3))
            SZ_B:    result = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    result = funct3[2] ? {16'b0, lane} : {{16{lane[15]}}, lane};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles on mem_ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_valid,
    output logic              ls_misalign,
    output logic              bus_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    arb_state_t        state, state_next;
    logic              last_ls;
    logic              if_pend, ls_pend, grant_if, grant_ls, ls_bad;
    logic              xfer_done, abort;
    logic [1:0]        ls_off_q;
    logic [2:0]        ls_f3_q;
    logic [31:0]       load_data, store_just, st_wdata;
    logic [BE_W-1:0]   st_be;

    // A requester whose valid is high this cycle is finished and must not win again.
    always_comb begin
        if_pend   = if_req & ~if_valid;
        ls_pend   = ls_req & ~ls_valid;
        grant_ls  = (state == IDLE) & ls_pend & (~if_pend | ~last_ls);
        grant_if  = (state == IDLE) & if_pend & ~grant_ls;
        ls_bad    = is_misaligned(ls_funct3, ls_addr[1:0]);
        xfer_done = (state != IDLE) & mem_ready;
    end

    assign stall = (if_req & ~if_valid) | (ls_req & ~ls_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_if)                state_next = IF_WAIT;
                else if (grant_ls && !ls_bad) state_next = LS_WAIT;
            end
            IF_WAIT, LS_WAIT: begin
                if (xfer_done || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Store lanes: the store data is right-justified first, then replicated across the word.
    always_comb begin
        case (access_size(ls_funct3))
            SZ_B: begin
                st_be    = 4'b0001 << ls_addr[1:0];
                st_wdata = {4{store_just[7:0]}};
            end
            SZ_H: begin
                st_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_just[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_just;
            end
        endcase
    end

    load_align u_store_align (
        .data   (ls_wdata),
        .offset (2'b00),
        .funct3 ({1'b1, ls_funct3[1:0]}),
        .result (store_just)
    );

    load_align u_load_align (
        .data   (mem_rdata),
        .offset (ls_off_q),
        .funct3 (ls_f3_q),
        .result (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata    <= '0;
            if_valid    <= 1'b0;
            ls_rdata    <= '0;
            ls_valid    <= 1'b0;
            ls_misalign <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            ls_off_q    <= '0;
            ls_f3_q     <= '0;
            last_ls     <= 1'b0;
        end else begin
            if_valid    <= 1'b0;
            ls_valid    <= 1'b0;
            ls_misalign <= 1'b0;
            if (grant_if) begin
                last_ls   <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr & WORD_MASK;
                mem_be    <= 4'b1111;
                mem_wdata <= '0;
            end else if (grant_ls) begin
                last_ls <= 1'b1;
                if (ls_bad) begin
                    ls_valid    <= 1'b1;
                    ls_misalign <= 1'b1;
                    ls_rdata    <= '0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= ls_we;
                    mem_addr  <= ls_addr & WORD_MASK;
                    mem_be    <= ls_we ? st_be : 4'b1111;
                    mem_wdata <= ls_we ? st_wdata : '0;
                    ls_off_q  <= ls_addr[1:0];
                    ls_f3_q   <= ls_funct3;
                end
            end
            if (xfer_done || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == IF_WAIT) begin
                    if_valid <= 1'b1;
                    if_rdata <= abort ? '0 : mem_rdata;
                end else begin
                    ls_valid <= 1'b1;
                    ls_rdata <= abort ? '0 : load_data;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign abort = (state != IDLE) & ~mem_ready & (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= abort;
            if (grant_if || grant_ls)
                wait_cnt <= '0;
            else if (state != IDLE && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, tie/reset sequences, and randomized traffic vs a byte-level memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [2:0]  ls_funct3;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, ls_valid, ls_misalign, bus_err, stall;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;

    logic        auto_mem, auto_ready, man_ready;
    logic [31:0] man_rdata;
    logic [31:0] mem_word [16];
    logic [7:0]  ref_mem  [64];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
        .ls_misalign(ls_misalign), .bus_err(bus_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Environment memory: honours mem_be on writes when in automatic mode.
    assign mem_ready = auto_mem ? auto_ready : man_ready;
    assign mem_rdata = auto_mem ? mem_word[mem_addr[5:2]] : man_rdata;

    always @(negedge clk) auto_ready <= ($urandom_range(0, 3) != 0);

    always @(posedge clk) begin
        if (auto_mem && mem_req && mem_ready && mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) mem_word[mem_addr[5:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    typedef struct {
        logic        is_if;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [16];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; memory answers with zero wait states.
    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        man_rdata = v.mrdata;
        man_ready = 1'b1;
        if (v.is_if) begin
            if_addr = v.addr;
            if_req  = 1'b1;
        end else begin
            ls_addr   = v.addr;
            ls_we     = v.we;
            ls_funct3 = v.f3;
            ls_wdata  = v.wdata;
            ls_req    = 1'b1;
        end
        #1 check_output({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        if (v.exp_mis) begin
            check_output({tag, "_mis_valid"}, {29'd0, ls_valid, ls_misalign, mem_req}, 32'b110);
            check_output({tag, "_mis_rdata"}, ls_rdata, 32'd0);
        end else begin
            check_output({tag, "_req_c1"}, {30'd0, mem_req, stall}, 32'b11);
            check_output({tag, "_addr"}, mem_addr, v.addr & ~32'd3);
            check_output({tag, "_be_we"}, {27'd0, mem_we, mem_be}, {27'd0, v.we, v.exp_be});
            if (v.we) check_output({tag, "_wdata"}, mem_wdata, v.exp_wdata);
            @(negedge clk);
            if (v.is_if) begin
                check_output({tag, "_if_valid"}, {30'd0, if_valid, stall}, 32'b10);
                check_output({tag, "_if_rdata"}, if_rdata, v.exp_rdata);
            end else begin
                check_output({tag, "_ls_valid"}, {29'd0, ls_valid, ls_misalign, stall}, 32'b100);
                if (!v.we) check_output({tag, "_ls_rdata"}, ls_rdata, v.exp_rdata);
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_access();
        logic        is_if, we, mis, got;
        logic [2:0]  f3;
        logic [31:0] wdata, expv;
        int          addr, nbytes;
        is_if = ($urandom_range(0, 3) == 0);
        addr  = $urandom_range(0, 63);
        we    = $urandom_range(0, 1) == 1;
        wdata = $urandom;
        case ($urandom_range(0, 5))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            4: f3 = 3'd5;
            default: f3 = 3'd3;
        endcase
        if (is_if) begin
            addr   = addr & ~3;
            nbytes = 4;
        end else begin
            case (f3)
                3'd0, 3'd4: nbytes = 1;
                3'd1, 3'd5: nbytes = 2;
                default:    nbytes = 4;
            endcase
        end
        mis  = !is_if && (addr % nbytes != 0);
        expv = 32'd0;
        if (!mis) begin
            for (int k = 0; k < nbytes; k++) expv = expv | (32'(ref_mem[addr + k]) << (8 * k));
            if (!is_if && (f3 == 3'd0 || f3 == 3'd1) && expv[8*nbytes-1])
                expv = expv | (~32'd0 << (8 * nbytes));
        end
        if (is_if) begin
            if_addr = addr;
            if_req  = 1'b1;
        end else begin
            ls_addr = addr; ls_we = we; ls_funct3 = f3; ls_wdata = wdata;
            ls_req  = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (is_if ? if_valid : ls_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_output("rand_completion", {31'd0, got}, 32'd1);
        if (got) begin
            check_output("rand_bus_err", {31'd0, bus_err}, 32'd0);
            if (is_if) begin
                check_output("rand_if_rdata", if_rdata, expv);
            end else begin
                check_output("rand_misalign", {31'd0, ls_misalign}, {31'd0, mis});
                if (!we || mis) check_output("rand_ls_rdata", ls_rdata, expv);
                if (we && !mis)
                    for (int k = 0; k < nbytes; k++) ref_mem[addr + k] = wdata[8*k +: 8];
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_funct3 = '0;
        auto_mem = 1'b0; man_ready = 1'b0; man_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem_word[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = mem_word[i][8*k +: 8];
        end

        vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 32'h0000_0013, 32'h0000_0013, 1'b0, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 4'hF, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 32'h0000_0080, 1'b0, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_1234, 32'h0000_80FF, 1'b0, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 3'd2, 32'h104, 32'h0, 32'h80FF_1234, 32'h80FF_1234, 1'b0, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 3'd1, 32'h100, 32'h0, 32'h80FF_1234, 32'h0000_1234, 1'b0, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00AB, 32'h0, 32'h0, 1'b0, 4'b0010, 32'hABAB_ABAB};
        vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h202, 32'hDEAD_1234, 32'h0, 32'h0, 1'b0, 4'b1100, 32'h1234_1234};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 32'h203, 32'h1234_5655, 32'h0, 32'h0, 1'b0, 4'b1000, 32'h5555_5555};
        vecs[11] = '{1'b0, 1'b0, 3'd2, 32'h106, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 3'd5, 32'h101, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 3'd3, 32'h102, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 3'd7, 32'h108, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 4'hF, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 3'd1, 32'h203, 32'h0000_BEEF, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0};

        repeat (3) @(negedge clk);
        check_output("reset_ctrl", {21'd0, mem_req, mem_we, if_valid, ls_valid, ls_misalign, bus_err, stall, mem_be}, 32'd0);
        check_output("reset_if_rdata", if_rdata, 32'd0);
        check_output("reset_ls_rdata", ls_rdata, 32'd0);
        check_output("reset_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Tie right after reset goes to LS, then alternates.
        man_ready = 1'b1; man_rdata = 32'h1111_2222;
        if_addr = 32'h40; ls_addr = 32'h100; ls_funct3 = 3'd2; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        @(negedge clk);
        check_output("tie1_grant_ls", mem_addr, 32'h100);
        @(negedge clk);
        check_output("tie1_ls_valid", {30'd0, ls_valid, if_valid}, 32'b10);
        ls_req = 1'b0;
        @(negedge clk);
        check_output("tie1_then_if", {31'd0, mem_req} + mem_addr, 32'h41);
        @(negedge clk);
        check_output("tie1_if_valid", {31'd0, if_valid}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; ls_req = 1'b1;
        @(negedge clk);
        check_output("tie2_grant_ls", mem_addr, 32'h100);
        @(negedge clk);
        check_output("tie2_ls_valid", {31'd0, ls_valid}, 32'd1);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; ls_req = 1'b1;
        @(negedge clk);
        check_output("tie3_grant_if", mem_addr, 32'h40);
        @(negedge clk);
        check_output("tie3_if_valid", {30'd0, if_valid, ls_valid}, 32'b10);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

        // Reset during LS_WAIT drops mem_req at once and yields no completion.
        man_ready = 1'b0;
        ls_addr = 32'h100; ls_funct3 = 3'd2; ls_we = 1'b0; ls_req = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_mid_before", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1 check_output("rst_mid_async", {31'd0, mem_req}, 32'd0);
        ls_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rst_mid_no_valid", {31'd0, ls_valid}, 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int cyc;
            logic got;
            man_ready = 1'b0;
            ls_addr = 32'h100; ls_funct3 = 3'd2; ls_we = 1'b0; ls_req = 1'b1;
            cyc = 0;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                cyc++;
                if (ls_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check_output("timeout_cycles", cyc, 32'd16);
            check_output("timeout_flags", {30'd0, got, bus_err}, 32'b11);
            check_output("timeout_rdata", ls_rdata, 32'd0);
            ls_req = 1'b0;
            @(negedge clk);
        end
`endif

        auto_mem = 1'b1;
        for (int i = 0; i < 300; i++) random_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
